// File: rtl/cell_pos_reader_if.sv
// Particle record stream from the cell reader to the position cache / force feeder.
// Valid/ready handshake. Each record carries its 1-based particle index and a last flag.
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] index;
    logic                  last;

    modport master (output valid, output data, output index, output last, input ready);
    modport slave  (input valid, input data, input index, input last, output ready);
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the count word and then every particle record from one cell memory and streams them out.
// Latency: the first record appears 7 cycles after start. After that, records flow at one per cycle.
// Backpressure: reads are credit-gated against the output FIFO, so a stalled consumer stops new reads.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    cell_pos_reader_if.master     out
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = FCW + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] index;
        logic                  last;
    } entry_t;

    state_t                state, state_nxt;
    logic                  wait_second;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [1:0]            pipe_vld;
    logic [ADDR_WIDTH-1:0] pipe_idx [2];
    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [FCW-1:0]        fifo_count;

    logic                  issue;
    logic                  push, pop;
    logic [CW-1:0]         credit_used;
    logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamped;
    entry_t                head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
    // Reads still in the pipe hold a FIFO slot, so the FIFO cannot overflow when they land.
    assign credit_used = CW'(fifo_count) + CW'(pipe_vld[0]) + CW'(pipe_vld[1]);

    assign push = pipe_vld[1];
    assign pop  = out.valid && out.ready;
    assign head = fifo_mem[rd_ptr];

    assign out.valid = (fifo_count != '0);
    assign out.data  = out.valid ? head.data  : '0;
    assign out.index = out.valid ? head.index : '0;
    assign out.last  = out.valid ? head.last  : 1'b0;
    assign mem_wren  = 1'b0;

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rden    = 1'b0;
        mem_address = last_addr;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RD_CNT;
            end
            RD_CNT: begin
                busy        = 1'b1;
                mem_rden    = 1'b1;
                mem_address = '0;
                state_nxt   = WAIT_CNT;
            end
            WAIT_CNT: begin
                busy = 1'b1;
                if (wait_second) state_nxt = (cnt_clamped == '0) ? DONE : STREAM;
            end
            STREAM: begin
                busy  = 1'b1;
                issue = (credit_used < CW'(FIFO_DEPTH));
                if (issue) begin
                    mem_rden    = 1'b1;
                    mem_address = next_addr;
                    if (next_addr == cell_count) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && out.last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_second <= 1'b0;
            next_addr   <= '0;
            last_addr   <= '0;
            cell_count  <= '0;
            count_err   <= 1'b0;
            pipe_vld    <= '0;
            pipe_idx[0] <= '0;
            pipe_idx[1] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state       <= state_nxt;
            wait_second <= (state == WAIT_CNT) && !wait_second;
            if (mem_rden) last_addr <= mem_address;

            if (state == WAIT_CNT && wait_second) begin
                cell_count <= cnt_clamped;
                next_addr  <= ADDR_WIDTH'(1);
                if (cnt_raw > MAX_CNT) count_err <= 1'b1;
            end else if (issue) begin
                next_addr <= next_addr + ADDR_WIDTH'(1);
            end

            pipe_vld    <= {pipe_vld[0], issue};
            pipe_idx[0] <= next_addr;
            pipe_idx[1] <= pipe_idx[0];

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{data: mem_q, index: pipe_idx[1], last: (pipe_idx[1] == cell_count)};
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_count == FCW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_cell_pos_reader.sv
module tb_cell_pos_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, count_err, mem_rden, mem_wren;
    logic [AW-1:0] cell_count, mem_address;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] rd1 = '0;

    cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

    cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cell_count(cell_count), .count_err(count_err), .mem_address(mem_address),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q), .out(out_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:PN-1];
    always @(posedge clk) begin
        rd1   <= (mem_rden && mem_address < AW'(PN)) ? mem[mem_address] : '0;
        mem_q <= rd1;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
    } rec_t;
    rec_t exp_q[$];

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0;
    int rd_cnt, a0_cnt, stream_rd, acc_cnt, max_out, valid_seen, done_cnt, done_cyc, first_v, last_v;
    int wren_seen;
    bit mon_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    int rdy_mode = 0;
    int ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_if.ready = 1'b1;
            else begin
                out_if.ready = (ph % 4 == 0) || (ph % 4 == 3);
                ph++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rden) begin
                rd_cnt++;
                if (mem_address == '0) a0_cnt++;
                else stream_rd++;
            end
            if (mem_wren !== 1'b0) wren_seen++;
            if (stream_rd - acc_cnt > max_out) max_out = stream_rd - acc_cnt;
            if (out_if.valid) begin
                valid_seen++;
                if (first_v < 0) first_v = cyc - start_cyc;
                if (stall_prev) begin
                    check("stall_data", out_if.data, prev_data);
                    check("stall_index", out_if.index, prev_idx);
                end
                if (out_if.ready) begin
                    if (exp_q.size() == 0) check("unexpected_valid", out_if.valid, 1'b0);
                    else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        check("rec_data", out_if.data, e.d);
                        check("rec_index", out_if.index, e.i);
                        check("rec_last", out_if.last, e.l);
                        acc_cnt++;
                        last_v = cyc - start_cyc;
                    end
                end
                stall_prev = !out_if.ready;
                prev_data  = out_if.data;
                prev_idx   = out_if.index;
            end else stall_prev = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; a0_cnt = 0; stream_rd = 0; acc_cnt = 0; max_out = 0;
        valid_seen = 0; done_cnt = 0; done_cyc = -1; first_v = -1; last_v = -1;
        wren_seen = 0; stall_prev = 1'b0;
    endtask

    task automatic prepare(input int stored, input int n_eff);
        logic [DW-1:0] w;
        w = {$urandom, $urandom, $urandom};
        w[AW-1:0] = AW'(stored);
        mem[0] = w;
        for (int i = 1; i < PN; i++) mem[i] = {$urandom, $urandom, $urandom};
        exp_q.delete();
        for (int i = 1; i <= n_eff; i++) exp_q.push_back('{d: mem[i], i: AW'(i), l: (i == n_eff)});
        clear_stats();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        check(tag, (done_cnt > 0), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < PN; i++) mem[i] = '0;
        clear_stats();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_valid", out_if.valid, 1'b0);
        check("rst_count", cell_count, '0);
        check("rst_err", count_err, 1'b0);
        check("rst_addr", mem_address, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // count 5, full throughput, exact cycle timing
        rdy_mode = 0;
        prepare(5, 5);
        pulse_start();
        @(negedge clk);
        check("c5_busy_c1", busy, 1'b1);
        check("c5_rden_c1", mem_rden, 1'b1);
        check("c5_addr_c1", mem_address, '0);
        wait_done("c5_done_timeout");
        check("c5_done_pulses", done_cnt, 1);
        check("c5_done_cycle", done_cyc, 12);
        check("c5_first_valid", first_v, 7);
        check("c5_last_valid", last_v, 11);
        check("c5_valid_cycles", valid_seen, 5);
        check("c5_rden_pulses", rd_cnt, 6);
        check("c5_remaining", exp_q.size(), 0);
        check("c5_cell_count", cell_count, 5);
        check("c5_count_err", count_err, 1'b0);
        check("c5_idle_busy", busy, 1'b0);
        check("c5_wren", wren_seen, 0);

        // count 0
        prepare(0, 0);
        pulse_start();
        wait_done("c0_done_timeout");
        check("c0_done_cycle", done_cyc, 4);
        check("c0_rden_pulses", rd_cnt, 1);
        check("c0_addr0_reads", a0_cnt, 1);
        check("c0_valid_seen", valid_seen, 0);
        check("c0_cell_count", cell_count, 0);
        check("c0_count_err", count_err, 1'b0);

        // count 8 with ready toggling 1,0,0,1
        rdy_mode = 1; ph = 0;
        prepare(8, 8);
        pulse_start();
        wait_done("c8_done_timeout");
        check("c8_remaining", exp_q.size(), 0);
        check("c8_accepted", acc_cnt, 8);
        check("c8_credit_bound", (max_out <= FD), 1'b1);
        check("c8_done_pulses", done_cnt, 1);
        check("c8_rden_pulses", rd_cnt, 9);
        rdy_mode = 0;

        // stored count 250 is clamped to 219
        prepare(250, PN - 1);
        pulse_start();
        wait_done("c250_done_timeout");
        check("c250_cell_count", cell_count, PN - 1);
        check("c250_count_err", count_err, 1'b1);
        check("c250_remaining", exp_q.size(), 0);
        check("c250_accepted", acc_cnt, PN - 1);
        check("c250_done_cycle", done_cyc, 7 + PN - 1);
        check("c250_credit_bound", (max_out <= FD), 1'b1);

        // reset in the middle of a pass, then a clean pass
        prepare(10, 10);
        pulse_start();
        for (int k = 0; k < 200 && acc_cnt < 3; k++) @(negedge clk);
        check("rstmid_reached", (acc_cnt >= 3), 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_rden", mem_rden, 1'b0);
        check("rstmid_valid", out_if.valid, 1'b0);
        check("rstmid_last", out_if.last, 1'b0);
        check("rstmid_index", out_if.index, '0);
        check("rstmid_addr", mem_address, '0);
        check("rstmid_count", cell_count, '0);
        check("rstmid_err", count_err, 1'b0);
        exp_q.delete();
        clear_stats();
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid_stale_valid", valid_seen, 0);
        prepare(5, 5);
        pulse_start();
        wait_done("rstnew_done_timeout");
        check("rstnew_remaining", exp_q.size(), 0);
        check("rstnew_accepted", acc_cnt, 5);
        check("rstnew_done_cycle", done_cyc, 12);

        // start re-asserted during STREAM is ignored
        prepare(6, 6);
        pulse_start();
        for (int k = 0; k < 200 && stream_rd < 2; k++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart_done_timeout");
        repeat (6) @(negedge clk);
        check("restart_done_pulses", done_cnt, 1);
        check("restart_addr0_reads", a0_cnt, 1);
        check("restart_rden_pulses", rd_cnt, 7);
        check("restart_remaining", exp_q.size(), 0);
        check("restart_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
